// File: rtl/wb_pkg.sv
// Shared writeback-stage types and constants: source selects, load funct3 codes,
// the accelerator request record and the load byte-lane alignment function.
package wb_pkg;

    localparam int WB_XLEN  = 32;
    localparam int WB_IDX_W = 5;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [WB_XLEN-1:0]  data;
        logic [WB_IDX_W-1:0] idx;
    } wb_req_t;

    // Sub-word results come back sign/zero extended to 32 bits; callers widen
    // with a signed cast, which is exact for the zero-extended forms too.
    function automatic logic [31:0] load_align(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  addr_lo);
        logic [7:0]  w_byte;
        logic [15:0] w_half;
        w_byte = word[{addr_lo, 3'b000} +: 8];
        w_half = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   load_align = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  load_align = {24'd0, w_byte};
            F3_LH:   load_align = {{16{w_half[15]}}, w_half};
            F3_LHU:  load_align = {16'd0, w_half};
            F3_LW:   load_align = word;
            default: load_align = word;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding accelerator results until a writeback slot frees up.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage is not reset; the count gates every read of it.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load formatting, merged with buffered
// accelerator results onto the single register-file write port.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN      = WB_XLEN,
    parameter int IDX_W     = WB_IDX_W,
    parameter int EXT_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  logic                         i_flush,
    input  logic [XLEN-1:0]              i_alu,
    input  logic [XLEN-1:0]              i_mem,
    input  logic [XLEN-1:0]              i_pc4,
    input  logic [IDX_W-1:0]             i_w_idx,
    input  logic [1:0]                   i_wb_sel,
    input  logic                         i_wb_en,
    input  logic [2:0]                   i_ld_funct3,
    input  logic [1:0]                   i_addr_lo,
    input  logic                         i_ext_valid,
    input  logic [XLEN-1:0]              i_ext_data,
    input  logic [IDX_W-1:0]             i_ext_idx,
    output logic                         o_ext_ready,
    output logic                         o_stall,
    output logic [XLEN-1:0]              o_wb_data,
    output logic [IDX_W-1:0]             o_w_idx,
    output logic                         o_wb_en,
    output logic [$clog2(EXT_DEPTH):0]   o_ext_count
);

    localparam int REQ_W = XLEN + IDX_W;

    logic                  r_pr_valid;
    logic [XLEN-1:0]       r_pr_data;
    logic [IDX_W-1:0]      r_pr_idx;

    logic [31:0]           w_ld_fmt;
    logic [XLEN-1:0]       w_ld_data;
    logic [XLEN-1:0]       w_cap_data;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [REQ_W-1:0]      w_head;

    assign w_ld_fmt  = load_align(i_mem[31:0], i_ld_funct3, i_addr_lo);
    assign w_ld_data = (i_ld_funct3 inside {F3_LB, F3_LBU, F3_LH, F3_LHU})
                       ? XLEN'($signed(w_ld_fmt)) : i_mem;

    always_comb begin
        case (i_wb_sel)
            WB_SEL_ALU: w_cap_data = i_alu;
            WB_SEL_MEM: w_cap_data = w_ld_data;
            WB_SEL_PC4: w_cap_data = i_pc4;
            default:    w_cap_data = i_alu;
        endcase
    end

    // Index-0 results are acknowledged upstream but never stored.
    assign w_push = i_ext_valid & ~w_full & (i_ext_idx != '0);

    wb_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (EXT_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_din   ({i_ext_data, i_ext_idx}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_ext_count)
    );

    // A full FIFO steals the slot and freezes the pipeline entry for one cycle.
    always_comb begin
        w_pop     = 1'b0;
        o_wb_en   = 1'b0;
        o_wb_data = '0;
        o_w_idx   = '0;
        if (w_full) begin
            w_pop     = 1'b1;
            o_wb_en   = 1'b1;
            o_wb_data = w_head[REQ_W-1:IDX_W];
            o_w_idx   = w_head[IDX_W-1:0];
        end else if (r_pr_valid) begin
            o_wb_en   = 1'b1;
            o_wb_data = r_pr_data;
            o_w_idx   = r_pr_idx;
        end else if (!w_empty) begin
            w_pop     = 1'b1;
            o_wb_en   = 1'b1;
            o_wb_data = w_head[REQ_W-1:IDX_W];
            o_w_idx   = w_head[IDX_W-1:0];
        end
    end

    assign o_stall     = w_full;
    assign o_ext_ready = ~w_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pr_valid <= 1'b0;
            r_pr_data  <= '0;
            r_pr_idx   <= '0;
        end else if (!w_full) begin
            r_pr_valid <= i_valid & i_wb_en & ~i_flush & (i_w_idx != '0);
            r_pr_data  <= w_cap_data;
            r_pr_idx   <= i_w_idx;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized checks of writeback_stage against a queue-based
// reference of the slot-grant rules.
module tb_writeback_stage;

    localparam int XLEN  = 32;
    localparam int IDX_W = 5;
    localparam int DEPTH = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic              i_flush = 1'b0;
    logic [XLEN-1:0]   i_alu = '0;
    logic [XLEN-1:0]   i_mem = '0;
    logic [XLEN-1:0]   i_pc4 = '0;
    logic [IDX_W-1:0]  i_w_idx = '0;
    logic [1:0]        i_wb_sel = '0;
    logic              i_wb_en = 1'b0;
    logic [2:0]        i_ld_funct3 = '0;
    logic [1:0]        i_addr_lo = '0;
    logic              i_ext_valid = 1'b0;
    logic [XLEN-1:0]   i_ext_data = '0;
    logic [IDX_W-1:0]  i_ext_idx = '0;
    logic              o_ext_ready;
    logic              o_stall;
    logic [XLEN-1:0]   o_wb_data;
    logic [IDX_W-1:0]  o_w_idx;
    logic              o_wb_en;
    logic [2:0]        o_ext_count;

    writeback_stage #(.XLEN(XLEN), .IDX_W(IDX_W), .EXT_DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_flush     (i_flush),
        .i_alu       (i_alu),
        .i_mem       (i_mem),
        .i_pc4       (i_pc4),
        .i_w_idx     (i_w_idx),
        .i_wb_sel    (i_wb_sel),
        .i_wb_en     (i_wb_en),
        .i_ld_funct3 (i_ld_funct3),
        .i_addr_lo   (i_addr_lo),
        .i_ext_valid (i_ext_valid),
        .i_ext_data  (i_ext_data),
        .i_ext_idx   (i_ext_idx),
        .o_ext_ready (o_ext_ready),
        .o_stall     (o_stall),
        .o_wb_data   (o_wb_data),
        .o_w_idx     (o_w_idx),
        .o_wb_en     (o_wb_en),
        .o_ext_count (o_ext_count)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_pr_v = 1'b0;
    logic [31:0] m_pr_d = '0;
    logic [4:0]  m_pr_i = '0;
    logic [31:0] mq_d[$];
    logic [4:0]  mq_i[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_result(input logic [1:0] sel, input logic [2:0] f3,
                                             input logic [1:0] addr, input logic [31:0] alu,
                                             input logic [31:0] mem, input logic [31:0] pc4);
        logic [31:0] b, h;
        b = (mem >> (8 * int'(addr))) & 32'hFF;
        h = (mem >> (16 * (int'(addr) / 2))) & 32'hFFFF;
        if (sel == 2'd2) return pc4;
        if (sel != 2'd1) return alu;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return mem;
        endcase
    endfunction

    task automatic model_reset();
        m_pr_v = 1'b0;
        m_pr_d = '0;
        m_pr_i = '0;
        mq_d.delete();
        mq_i.delete();
    endtask

    // Compare the DUT against the model's current state, then advance both one edge.
    task automatic tick();
        bit          full, pop;
        logic        e_en;
        logic [31:0] e_d;
        logic [4:0]  e_i;
        full = (mq_d.size() == DEPTH);
        pop  = 1'b0;
        e_en = 1'b0; e_d = '0; e_i = '0;
        if (full) begin
            pop = 1'b1; e_en = 1'b1; e_d = mq_d[0]; e_i = mq_i[0];
        end else if (m_pr_v) begin
            e_en = 1'b1; e_d = m_pr_d; e_i = m_pr_i;
        end else if (mq_d.size() > 0) begin
            pop = 1'b1; e_en = 1'b1; e_d = mq_d[0]; e_i = mq_i[0];
        end
        chk("wb_en",     32'(o_wb_en),     32'(e_en));
        chk("wb_data",   o_wb_data,        e_d);
        chk("w_idx",     32'(o_w_idx),     32'(e_i));
        chk("stall",     32'(o_stall),     32'(full));
        chk("ext_ready", 32'(o_ext_ready), 32'(!full));
        chk("ext_count", 32'(o_ext_count), 32'(mq_d.size()));
        @(posedge i_clk);
        #1;
        if (!i_rst_n) begin
            model_reset();
        end else begin
            if (pop) begin
                void'(mq_d.pop_front());
                void'(mq_i.pop_front());
            end
            if (i_ext_valid && !full && i_ext_idx != 0) begin
                mq_d.push_back(i_ext_data);
                mq_i.push_back(i_ext_idx);
            end
            if (!full) begin
                m_pr_v = i_valid && i_wb_en && !i_flush && (i_w_idx != 0);
                m_pr_d = m_result(i_wb_sel, i_ld_funct3, i_addr_lo, i_alu, i_mem, i_pc4);
                m_pr_i = i_w_idx;
            end
        end
    endtask

    task automatic set_pipe(input logic v, input logic fl, input logic en, input logic [1:0] sel,
                            input logic [2:0] f3, input logic [1:0] addr, input logic [31:0] alu,
                            input logic [31:0] mem, input logic [31:0] pc4, input logic [4:0] idx);
        i_valid = v; i_flush = fl; i_wb_en = en; i_wb_sel = sel; i_ld_funct3 = f3;
        i_addr_lo = addr; i_alu = alu; i_mem = mem; i_pc4 = pc4; i_w_idx = idx;
    endtask

    task automatic set_ext(input logic v, input logic [31:0] d, input logic [4:0] idx);
        i_ext_valid = v; i_ext_data = d; i_ext_idx = idx;
    endtask

    task automatic idle();
        set_pipe(0, 0, 0, 2'd0, 3'd0, 2'd0, 0, 0, 0, 5'd0);
        set_ext(0, 0, 5'd0);
    endtask

    initial begin
        #2;
        chk("rst_wb_en", 32'(o_wb_en), 32'd0);
        chk("rst_ready", 32'(o_ext_ready), 32'd1);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();

        // Load formatting
        set_pipe(1, 0, 1, 2'd1, 3'd0, 2'd2, 0, 32'h1280_3456, 0, 5'd7);
        tick();
        chk("lb_data", o_wb_data, 32'hFFFF_FF80);
        chk("lb_idx", 32'(o_w_idx), 32'd7);
        set_pipe(1, 0, 1, 2'd1, 3'd4, 2'd2, 0, 32'h1280_3456, 0, 5'd7);
        tick();
        chk("lbu_data", o_wb_data, 32'h0000_0080);
        set_pipe(1, 0, 1, 2'd1, 3'd5, 2'd3, 0, 32'h1280_3456, 0, 5'd7);
        tick();
        chk("lhu_data", o_wb_data, 32'h0000_1280);
        set_pipe(1, 0, 1, 2'd1, 3'd1, 2'd1, 0, 32'h1280_F456, 0, 5'd8);
        tick();
        chk("lh_data", o_wb_data, 32'hFFFF_F456);

        // Pipeline has priority; accelerator result fills the first idle slot
        for (int k = 1; k <= 4; k++) begin
            set_pipe(1, 0, 1, 2'd0, 3'd0, 2'd0, 32'h1000 + 32'(k), 0, 0, 5'(k));
            if (k == 1) set_ext(1, 32'hA5, 5'd9); else set_ext(0, 0, 5'd0);
            tick();
            chk("seq_idx", 32'(o_w_idx), 32'(k));
        end
        idle();
        tick();
        chk("ext_idle_idx", 32'(o_w_idx), 32'd9);
        chk("ext_idle_data", o_wb_data, 32'hA5);
        tick();

        // Fill the FIFO under continuous pipeline traffic
        for (int k = 0; k < 4; k++) begin
            set_pipe(1, 0, 1, 2'd0, 3'd0, 2'd0, 32'h100 + 32'(k), 0, 0, 5'(10 + k));
            set_ext(1, 32'hE0 + 32'(k), 5'(20 + k));
            tick();
        end
        set_ext(0, 0, 5'd0);
        chk("full_count", 32'(o_ext_count), 32'd4);
        chk("full_stall", 32'(o_stall), 32'd1);
        chk("full_ready", 32'(o_ext_ready), 32'd0);
        chk("full_head", o_wb_data, 32'hE0);
        set_pipe(1, 0, 1, 2'd0, 3'd0, 2'd0, 32'h200, 0, 0, 5'd15);
        tick();
        chk("held_data", o_wb_data, 32'h103);
        chk("held_idx", 32'(o_w_idx), 32'd13);
        chk("held_stall", 32'(o_stall), 32'd0);
        idle();
        for (int k = 0; k < 6; k++) tick();

        // Discarded writes
        set_pipe(1, 0, 1, 2'd0, 3'd0, 2'd0, 32'h77, 0, 0, 5'd0);
        tick();
        chk("x0_no_write", 32'(o_wb_en), 32'd0);
        set_pipe(1, 1, 1, 2'd0, 3'd0, 2'd0, 32'h77, 0, 0, 5'd5);
        tick();
        chk("flush_no_write", 32'(o_wb_en), 32'd0);
        idle();
        set_ext(1, 32'h99, 5'd0);
        tick();
        chk("ext_x0_count", 32'(o_ext_count), 32'd0);
        chk("ext_x0_no_write", 32'(o_wb_en), 32'd0);

        // PC+4 and alternate ALU select
        set_pipe(1, 0, 1, 2'd2, 3'd0, 2'd0, 32'h55, 0, 32'h104, 5'd3);
        set_ext(0, 0, 5'd0);
        tick();
        chk("pc4_data", o_wb_data, 32'h104);
        set_pipe(1, 0, 1, 2'd3, 3'd0, 2'd0, 32'h55, 0, 32'h104, 5'd3);
        tick();
        chk("sel3_data", o_wb_data, 32'h55);

        // Reset mid-stream with two results buffered
        for (int k = 0; k < 2; k++) begin
            set_pipe(1, 0, 1, 2'd0, 3'd0, 2'd0, 32'h300 + 32'(k), 0, 0, 5'(1 + k));
            set_ext(1, 32'hC0 + 32'(k), 5'(25 + k));
            tick();
        end
        chk("pre_rst_count", 32'(o_ext_count), 32'd2);
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_wb_en", 32'(o_wb_en), 32'd0);
        chk("async_rst_data", o_wb_data, 32'd0);
        chk("async_rst_count", 32'(o_ext_count), 32'd0);
        model_reset();
        tick();
        chk("rst_edge_ready", 32'(o_ext_ready), 32'd1);
        i_rst_n = 1'b1;
        idle();
        tick();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            set_pipe(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                     $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
            set_ext(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)));
            if (c == 250) i_rst_n = 1'b0;
            if (c == 252) i_rst_n = 1'b1;
            tick();
        end
        idle();
        for (int k = 0; k < 8; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Registered MEM/WB writeback stage for the RISC-V core. It holds one pipeline entry, applies load sign/zero extension and byte-lane alignment, and selects the writeback source. It merges a second, variable-latency result stream from the WOS filter accelerator into the single register-file write port. Accelerator results are held in a small FIFO and drained into idle writeback slots; the stage back-pressures the pipeline only when that FIFO is full.

Parameters:
XLEN, 32, datapath width (multiple of 16)
IDX_W, 5, register index width
EXT_DEPTH, 4, accelerator result FIFO depth (power of 2, >=2)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_valid  input  1  MEM-stage entry valid
i_flush  input  1  kill the entry being captured this cycle
i_alu  input  XLEN  ALU result
i_mem  input  XLEN  raw memory read word
i_pc4  input  XLEN  PC+4
i_w_idx  input  IDX_W  destination register
i_wb_sel  input  2  0=ALU, 1=MEM, 2=PC4, 3=ALU
i_wb_en  input  1  instruction writes rd
i_ld_funct3  input  3  load funct3 (LB/LH/LW/LBU/LHU)
i_addr_lo  input  2  load address bits [1:0]
i_ext_valid  input  1  accelerator result valid
i_ext_data  input  XLEN  accelerator result
i_ext_idx  input  IDX_W  accelerator destination register
o_ext_ready  output  1  FIFO can accept (= !full)
o_stall  output  1  hold MEM stage and upstream
o_wb_data  output  XLEN  register-file write data
o_w_idx  output  IDX_W  register-file write index
o_wb_en  output  1  register-file write enable
o_ext_count  output  clog2(EXT_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, active-low): pr_valid=0, FIFO pointers and count=0, all pipeline fields=0. Outputs during and after reset: o_wb_en=0, o_wb_data=0, o_w_idx=0, o_stall=0, o_ext_ready=1, o_ext_count=0.
- Pipeline register: loads all fields on an edge when !o_stall. The loaded pr_valid = i_valid & i_wb_en & !i_flush & (i_w_idx!=0). Writes to x0 are discarded at capture. When o_stall=1 the register holds, and i_flush is ignored.
- Latency: a MEM-stage entry appears on o_wb_* exactly 1 cycle after capture, unless a full FIFO takes the slot (see the grant rules). Outputs are combinational from state only; there is no input-to-output combinational path.
- Load formatting (applies only when wb_sel=1): lane = addr_lo*8.
  - LB: sign-extend byte[lane].
  - LBU: zero-extend byte[lane].
  - LH: sign-extend halfword[addr_lo[1]*16]; addr_lo[0] is ignored.
  - LHU: zero-extend the same halfword.
  - LW and all other funct3 values: word unchanged.
- FIFO: push when i_ext_valid & o_ext_ready and i_ext_idx!=0. Entries with idx 0 are accepted and dropped, not stored. Pop when granted. Push and pop in the same cycle leave the count unchanged. Order is strictly FIFO.
- Grant, evaluated each cycle from registered state:
  1. count==EXT_DEPTH: FIFO head wins, o_stall=1, pr held.
  2. Else if pr_valid: pipeline entry wins, o_stall=0.
  3. Else if count>0: FIFO head wins.
  4. Else: o_wb_en=0, o_wb_data=0, o_w_idx=0.
- A full FIFO stalls for exactly one cycle per pop. While full, o_ext_ready=0, so no push can arrive. The next cycle the count is EXT_DEPTH-1, and pr (if valid) writes.
- A FIFO entry and the pipeline entry may target the same register. Writes commit in grant order, which the hazard unit accounts for. This block does not merge or cancel such writes.
- Reset asserted mid-operation clears all entries; buffered accelerator results are lost.
- o_ext_count equals the registered count.

Decomposition:
- Package wb_pkg holds:
  - WB_SEL_ALU/MEM/PC4 constants
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
  - a wb_req struct {data, idx}
- Sub-module wb_fifo: synchronous FIFO, parameters WIDTH and DEPTH, push/pop/full/empty/count, asynchronous active-low reset.
- Load alignment is a pure function in wb_pkg.

Test Plan:
- Reset pulse mid-stream with FIFO count=2 -> all outputs 0, o_ext_ready=1, o_ext_count=0 on the next edge.
- i_valid=1, wb_sel=1, funct3=LB, addr_lo=2, i_mem=0x12_80_34_56, idx=7 -> next cycle o_wb_en=1, o_w_idx=7, o_wb_data=0xFFFFFF80. Same with LBU -> 0x00000080. LHU with addr_lo=3 -> 0x00001280.
- Back-to-back ALU writes idx 1..4 while i_ext_valid=1 with idx 9, data 0xA5 -> pipeline writes 1..4 in order. 0xA5 is written to x9 on the first idle cycle. o_stall stays 0.
- Continuous pipeline writes; accelerator pushes EXT_DEPTH entries -> count reaches 4, o_ext_ready=0, o_stall=1 for one cycle with the FIFO head written. The held pr writes the next cycle with an unchanged value.
- i_w_idx=0 with wb_en=1, and i_flush=1 on an idx-5 entry -> no write occurs in either case. ext idx 0 -> accepted, count unchanged.
- wb_sel=2 with i_pc4=0x104, and wb_sel=3 with i_alu=0x55 -> o_wb_data 0x104, then 0x55.
